// File: rtl/sw_input_port.sv
// -----------------------------------------------------------------------------
// sw_input_port
//
// Switch input peripheral for the MINI_CPU. The module synchronizes the raw
// board switches and debounces them. It keeps a stable copy of the switch
// value and sets a sticky "changed" flag whenever that copy updates. The CPU
// reads the stable copy through a two-state valid/ack handshake.
//
// Parameters
//   DATA_WIDTH       switch / data width
//   DEBOUNCE_CYCLES  number of consecutive equal synchronized samples needed
//                    before a new value is accepted (must be >= 1)
//
// Ports
//   CLK       in   rising-edge clock
//   RST       in   asynchronous active-low reset
//   SW        in   raw switch levels, asynchronous to CLK
//   rd_req    in   read request, sampled only in IDLE
//   rd_ack    in   read acknowledge, sampled only in RESP
//   rd_data   out  stable value captured when the request was accepted
//   rd_valid  out  rd_data is valid; held until acknowledged
//   stable    out  current debounced switch value
//   changed   out  stable has changed since the last accepted read
// -----------------------------------------------------------------------------
module sw_input_port #(
  parameter int DATA_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] SW,
  input  logic                  rd_req,
  input  logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] stable,
  output logic                  changed
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Synchronizer and debounce state
  logic [DATA_WIDTH-1:0] sync1_q;
  logic [DATA_WIDTH-1:0] sw_s_q;
  logic [DATA_WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]      cnt_q,  cnt_d;
  logic [DATA_WIDTH-1:0] stable_q, stable_d;

  // Read handshake state
  state_t                state_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  changed_q;

  logic                  accept_w;
  logic                  rd_take_w;

  // The candidate has been seen for the full window and differs from the
  // current stable value.
  assign accept_w  = (cnt_q == CNT_MAX) && (sw_s_q == cand_q) && (cand_q != stable_q);
  assign rd_take_w = (state_q == IDLE) && rd_req;

  // Debounce next-state. Any mismatch between the synchronized input and the
  // candidate restarts the window, so short glitches never reach stable.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sw_s_q != cand_q) begin
      cand_d = sw_s_q;
      cnt_d  = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (accept_w) begin
      stable_d = cand_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q  <= '0;
      sw_s_q   <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= SW;
      sw_s_q   <= sync1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Read FSM plus the sticky changed flag. A stable update in the same cycle
  // as an accepted read keeps changed set: the read returns the old value, so
  // the new one has not been seen yet.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_req) begin
            rd_data_q  <= stable_q;
            rd_valid_q <= 1'b1;
            state_q    <= RESP;
          end
        end
        RESP: begin
          // Requests are ignored here; only the ack matters.
          if (rd_ack) begin
            rd_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          rd_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase

      if (accept_w) begin
        changed_q <= 1'b1;
      end else if (rd_take_w) begin
        changed_q <= 1'b0;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign stable   = stable_q;
  assign changed  = changed_q;

endmodule

// File: doc/sw_input_port.md
# sw_input_port

Switch input peripheral that supplies the MINI_CPU with debounced `SW` values. It synchronizes and debounces the asynchronous board switches, holds a stable copy, and raises a sticky `changed` flag when that copy changes. It answers CPU reads through a valid/ack handshake. It sits between the board `SW` pins and the CPU's input port, on the opposite side of the CPU from the HEX/`outp` output path.

## Interface
Parameters:
- `DATA_WIDTH`, 8: switch and data width (matches `` `DATA_WIDTH ``).
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required before acceptance; legal values are 1 and above.

Ports:
- `CLK`  input  1  the single clock; all logic is on the rising edge.
- `RST`  input  1  reset, asynchronous, active-low.
- `SW`  input  DATA_WIDTH  raw switch levels, asynchronous to `CLK`.
- `rd_req`  input  1  CPU read request, sampled only in IDLE.
- `rd_ack`  input  1  CPU has consumed `rd_data`, sampled only in RESP.
- `rd_data`  output  DATA_WIDTH  debounced value captured at request time.
- `rd_valid`  output  1  `rd_data` is valid; held until acknowledged.
- `stable`  output  DATA_WIDTH  current debounced switch value.
- `changed`  output  1  sticky flag: `stable` has changed since the last accepted read.

## Operation
- **Synchronizer:** two flops, `sync1` then `sw_s`.
- **Debounce path:**
  - Registers are `cand` (DATA_WIDTH) and `cnt`, which is $clog2(DEBOUNCE_CYCLES)+1 bits wide and saturates at DEBOUNCE_CYCLES-1.
  - If `sw_s != cand`: `cand <= sw_s`, `cnt <= 0`.
  - Else, if `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - If `cnt == DEBOUNCE_CYCLES-1` and `sw_s == cand` and `cand != stable`: `stable <= cand`, `changed <= 1`.
  - Any difference between `sw_s` and `cand` restarts the count, so a glitch shorter than the window never reaches `stable`.
- **Read FSM (2 states):**
  - IDLE: if `rd_req`, then `rd_data <= stable`, `rd_valid <= 1`, `changed <= 0`, and go to RESP.
  - RESP: `rd_valid` and `rd_data` hold. If `rd_ack`, then `rd_valid <= 0` and go to IDLE. `rd_req` is ignored in RESP.
- **Simultaneous events:**
  - A `stable` update in the same cycle as an accepted `rd_req`: `rd_data` gets the old `stable`, and `changed` ends at 1 (set wins over clear).
  - `rd_req` and `rd_ack` together in RESP: only the ack acts; the request is dropped.
  - `rd_ack` in IDLE: ignored.
- **Reset (`RST` low):** takes effect immediately, without waiting for a clock edge, including mid-debounce or mid-handshake.
  - `sync1`, `sw_s`, `cand`, `cnt`, `stable`, `rd_data` are 0.
  - `changed` and `rd_valid` are 0; the FSM is in IDLE.
  - After release, a nonzero `SW` is accepted as a normal change.

## Timing
- **SW to `stable`:** number the rising edge that first samples a new `SW` value as edge 1. `stable` and `changed` update on edge DEBOUNCE_CYCLES+3, provided `SW` stays constant throughout; with the default of 4 that is edge 7.
- **Minimum accepted pulse:** DEBOUNCE_CYCLES+1 cycles of constant `sw_s`.
- **Request:** `rd_req` sampled high in IDLE at edge t gives `rd_valid`=1, `rd_data` valid and `changed`=0 after edge t (1-cycle latency).
- **Ack:** `rd_ack` sampled high at edge u gives `rd_valid`=0 after edge u. The earliest next accepted `rd_req` is at edge u+1.
- **Back-to-back reads:** throughput is one completed read per 2 cycles at most.
- **Output timing:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
(All scenarios use DEBOUNCE_CYCLES=4.)
- **Reset with switches set:** hold `RST` low with `SW`=8'hA5, then release. Expect `stable`=8'h00 and `changed`=0 through edge 6, and `stable`=8'hA5 with `changed`=1 after edge 7.
- **Glitch rejection:** with `stable`=8'h00, drive `SW`=8'h3C for 4 cycles, then 8'h00. Expect `stable` to stay 8'h00 and `changed` to stay 0 for the next 20 cycles.
- **Read handshake:**
  - Setup: `stable`=8'h5A, `changed`=1.
  - Pulse `rd_req` for 1 cycle. Expect `rd_valid`=1, `rd_data`=8'h5A and `changed`=0 on the next cycle.
  - Keep `rd_ack` low for 5 cycles. Expect `rd_valid` still 1 and a second `rd_req` pulse ignored.
  - Assert `rd_ack`. Expect `rd_valid`=0 on the next cycle.
- **Update coincides with read:** arrange for `stable` to go 8'h11→8'h22 on the same edge that accepts `rd_req`. Expect `rd_data`=8'h11, `changed`=1, `stable`=8'h22.
- **Reset mid-handshake and mid-debounce:**
  - Setup: `rd_valid`=1, and `SW` changed to 8'hFF 2 cycles earlier.
  - Pulse `RST` low between clock edges. Expect `rd_valid`, `changed`, `stable` and `rd_data` at 0 immediately, before the next edge.
  - After release, expect `stable`=8'hFF 7 edges later.
